// File: rtl/pipe_fetch_pkg.sv
// Shared CPU definitions: redirect source encodings, reset vector and the
// fetch-queue entry layout used by the fetch stage.
package pipe_fetch_pkg;

  typedef enum logic [1:0] {
    PCSRC_NONE = 2'd0,
    PCSRC_JR   = 2'd1,
    PCSRC_BR   = 2'd2,
    PCSRC_J    = 2'd3
  } pcsrc_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc8;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO with synchronous flush; head is read straight from
// the storage flops so it stays stable until popped.
module fetch_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     resetn_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && (count_q != FULL_CNT);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; valid_o is gated by count, so stale contents never escape.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/pipe_fetch.sv
// Instruction fetch stage: PC generation, redirect target selection and
// one-cycle-latency IRAM reads feeding a small decoupling queue.
module pipe_fetch
  import pipe_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned QDEPTH   = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,
  output logic              iram_ena,
  output logic [ADDR_W-1:0] iram_addr,
  input  logic [31:0]       iram_rdata,
  input  logic              redirect,
  input  logic [1:0]        pcsource,
  input  logic [31:0]       br_pc,
  input  logic [31:0]       pc_jr,
  input  logic [17:0]       imm18,
  input  logic [27:0]       index28,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_pc8
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  localparam logic [CW:0] QDEPTH_L = (CW+1)'(QDEPTH);

  logic [31:0]   pc_q, pc_d;
  logic          infl_q, infl_d;
  logic [31:0]   infl_pc_q, infl_pc_d;
  logic [31:0]   target_raw, target;
  logic          redirect_go;
  logic          pop;
  logic [CW-1:0] q_count;
  logic [CW:0]   load;
  pcsrc_e        pcsel;
  fetch_entry_t  push_entry, head_entry;

  assign pcsel       = pcsrc_e'(pcsource);
  assign redirect_go = redirect && (pcsel != PCSRC_NONE);

  always_comb begin
    target_raw = pc_jr;
    case (pcsel)
      PCSRC_BR: target_raw = br_pc + {{14{imm18[17]}}, imm18};
      PCSRC_J:  target_raw = {br_pc[31:28], index28};
      default:  target_raw = pc_jr;
    endcase
    target = target_raw & 32'hFFFF_FFFC;
  end

  // Count the head leaving this edge so a draining queue keeps streaming.
  assign pop      = out_valid && out_ready;
  assign load     = {1'b0, q_count} + (CW+1)'(infl_q) - (CW+1)'(pop);
  assign iram_ena = resetn && (load < QDEPTH_L);
  assign iram_addr = pc_q[ADDR_W+1:2];

  always_comb begin
    pc_d      = pc_q;
    infl_d    = 1'b0;
    infl_pc_d = infl_pc_q;
    if (redirect_go) begin
      pc_d = target;
    end else if (iram_ena) begin
      pc_d      = pc_q + 32'd4;
      infl_d    = 1'b1;
      infl_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q      <= RESET_PC;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
    end else begin
      pc_q      <= pc_d;
      infl_q    <= infl_d;
      infl_pc_q <= infl_pc_d;
    end
  end

  // A redirect flushes the queue and also drops any read returning this edge.
  assign push_entry = '{inst: iram_rdata, pc: infl_pc_q, pc8: infl_pc_q + 32'd8};

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk_i    (clk),
    .resetn_i (resetn),
    .flush_i  (redirect_go),
    .push_i   (infl_q),
    .data_i   (push_entry),
    .pop_i    (out_ready),
    .valid_o  (out_valid),
    .data_o   (head_entry),
    .count_o  (q_count)
  );

  assign out_inst = head_entry.inst;
  assign out_pc   = head_entry.pc;
  assign out_pc8  = head_entry.pc8;

endmodule

// File: tb/tb_pipe_fetch.sv
// Directed bench for pipe_fetch: an IRAM model answers reads, expected PCs are
// queued as stimulus is applied and compared when the head is accepted.
module tb_pipe_fetch;
  import pipe_fetch_pkg::*;

  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              resetn;
  logic              iram_ena;
  logic [ADDR_W-1:0] iram_addr;
  logic [31:0]       iram_rdata = '0;
  logic              redirect;
  logic [1:0]        pcsource;
  logic [31:0]       br_pc, pc_jr;
  logic [17:0]       imm18;
  logic [27:0]       index28;
  logic              out_valid, out_ready;
  logic [31:0]       out_inst, out_pc, out_pc8;

  int total = 0;
  int bad = 0;
  int delivered = 0;
  logic [31:0] sb [$];

  pipe_fetch #(.ADDR_W(ADDR_W), .QDEPTH(2), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .iram_ena   (iram_ena),
    .iram_addr  (iram_addr),
    .iram_rdata (iram_rdata),
    .redirect   (redirect),
    .pcsource   (pcsource),
    .br_pc      (br_pc),
    .pc_jr      (pc_jr),
    .imm18      (imm18),
    .index28    (index28),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_inst   (out_inst),
    .out_pc     (out_pc),
    .out_pc8    (out_pc8)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [9:0] a);
    return {a, ~a, 12'hA5C};
  endfunction

  always @(posedge clk) begin
    if (iram_ena) iram_rdata <= inst_of(iram_addr);
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head();
    logic [31:0] exp_pc;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      exp_pc = sb.pop_front();
      check("out_pc", out_pc, exp_pc);
      check("out_pc8", out_pc8, exp_pc + 32'd8);
      check("out_inst", out_inst, inst_of(exp_pc[11:2]));
    end
    delivered++;
  endtask

  task automatic adv();
    if (out_valid && out_ready) check_head();
    tick();
  endtask

  task automatic expect_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) sb.push_back(start + 32'(4 * i));
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin
      adv();
      n++;
    end
    check(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic deliver(input int n, input int budget);
    int start = delivered;
    int cyc = 0;
    while ((delivered - start) < n && cyc < budget) begin
      adv();
      cyc++;
    end
    check("deliver_count", 32'(delivered - start), 32'(n));
  endtask

  task automatic do_reset(input logic rdy);
    resetn = 1'b0;
    out_ready = rdy;
    tick();
    resetn = 1'b1;
    sb.delete();
    expect_seq(32'h0, 8);
  endtask

  task automatic redirect_clean(input logic [1:0] src, input logic [31:0] bpc,
                                input logic [31:0] jr, input logic [17:0] imm,
                                input logic [27:0] idx, input logic [31:0] tgt);
    out_ready = 1'b0;
    redirect  = 1'b1;
    pcsource  = src;
    br_pc     = bpc;
    pc_jr     = jr;
    imm18     = imm;
    index28   = idx;
    tick();
    redirect = 1'b0;
    pcsource = 2'd0;
    sb.delete();
    expect_seq(tgt, 4);
    check("redir_addr", 32'(iram_addr), 32'(tgt[ADDR_W+1:2]));
    check("redir_flush", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    tick();
    check("redir_n1_valid", 32'(out_valid), 32'd0);
    tick();
    check("redir_n2_valid", 32'(out_valid), 32'd1);
    deliver(2, 8);
  endtask

  initial begin
    int d0;
    resetn = 1'b0; redirect = 1'b0; pcsource = 2'd0; br_pc = '0; pc_jr = '0;
    imm18 = '0; index28 = '0; out_ready = 1'b0;
    repeat (3) tick();
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_ena", 32'(iram_ena), 32'd0);

    // Release with downstream ready: 0x0, 0x4, 0x8 back to back.
    out_ready = 1'b1;
    resetn = 1'b1;
    sb.delete();
    expect_seq(32'h0, 8);
    #1;
    check("rel_addr", 32'(iram_addr), 32'h0);
    check("rel_ena", 32'(iram_ena), 32'd1);
    tick();
    check("rel_valid_e1", 32'(out_valid), 32'd0);
    tick();
    check("rel_valid_e2", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("stream_valid", 32'(out_valid), 32'd1);
      adv();
    end

    // Backpressure for 5 cycles after the first valid.
    do_reset(1'b0);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_head", out_pc, 32'h0);
      check("stall_ena", 32'(iram_ena), 32'd0);
      tick();
    end
    check("stall_pc_hold", 32'(iram_addr), 32'd2);
    out_ready = 1'b1;
    #1;
    check("resume_ena", 32'(iram_ena), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("resume_valid", 32'(out_valid), 32'd1);
      adv();
    end

    // Branch, jump and register-jump redirects.
    redirect_clean(2'd2, 32'h0000_0100, 32'h0, 18'h3FFF0, 28'h0, 32'h0000_00F0);
    redirect_clean(2'd3, 32'hA000_0010, 32'h0, 18'h0, 28'h0000400, 32'hA000_0400);
    redirect_clean(2'd1, 32'h0, 32'h0000_0203, 18'h0, 28'h0, 32'h0000_0200);

    // redirect with pcsource=0 must not disturb the stream.
    expect_seq(32'h0000_0210, 6);
    redirect = 1'b1;
    pcsource = 2'd0;
    br_pc = 32'h0000_0100;
    pc_jr = 32'h0000_0400;
    adv();
    redirect = 1'b0;
    deliver(4, 10);

    // Redirect on the same edge as the transfer of head 0x8.
    do_reset(1'b1);
    wait_valid("coinc_start", 6);
    adv();
    adv();
    check("coinc_head", out_pc, 32'h8);
    redirect = 1'b1;
    pcsource = 2'd1;
    pc_jr = 32'h0000_0300;
    d0 = delivered;
    adv();
    redirect = 1'b0;
    pcsource = 2'd0;
    check("coinc_delivered", 32'(delivered - d0), 32'd1);
    sb.delete();
    expect_seq(32'h0000_0300, 4);
    wait_valid("coinc_valid", 6);
    deliver(3, 10);

    // Reset mid-stream with a full queue.
    out_ready = 1'b0;
    repeat (4) tick();
    check("full_valid", 32'(out_valid), 32'd1);
    check("full_ena", 32'(iram_ena), 32'd0);
    resetn = 1'b0;
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ena", 32'(iram_ena), 32'd0);
    resetn = 1'b1;
    #1;
    check("rst_addr", 32'(iram_addr), 32'h0);
    out_ready = 1'b1;
    sb.delete();
    expect_seq(32'h0, 4);
    wait_valid("rst_restart", 6);
    deliver(3, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
